// File: rtl/seq_multdiv.sv
// Iterative signed multiplier/divider: radix-2 shift-add multiply and restoring divide
// on sign-magnitude operands, with a start/ready handshake and overflow/div-by-zero flag.
module seq_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t               state_q, state_d;
  logic                 div_q, div_d;
  logic                 neg_q, neg_d;
  logic                 dz_q, dz_d;
  logic                 dovf_q, dovf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]       mag_a_q, mag_a_d;
  logic [WIDTH:0]       mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 exc_q, exc_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;

  logic [WIDTH:0]       start_mag_a, start_mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH+1:0]     rem_shift, trial;
  logic [2*WIDTH-1:0]   prod_signed;
  logic [WIDTH-1:0]     quo_signed;

  // WIDTH+1 bits so that the magnitude of the most negative operand is representable.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return ext[WIDTH] ? -ext : ext;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v,
                                                         input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    start_mag_a = magnitude(data_operandA);
    start_mag_b = magnitude(data_operandB);
    mul_sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + mag_a_q;
    rem_shift   = {rem_q, quo_q[WIDTH-1]};
    trial       = rem_shift - {1'b0, mag_b_q};
    prod_signed = apply_sign_wide(prod_q, neg_q);
    quo_signed  = apply_sign(quo_q, neg_q);

    state_d  = state_q;
    div_d    = div_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    dovf_d   = dovf_q;
    cnt_d    = cnt_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE: begin
        if (ctrl_MULT || ctrl_DIV) begin
          state_d = S_RUN;
          div_d   = ~ctrl_MULT;
          busy_d  = 1'b1;
          cnt_d   = '0;
          mag_a_d = start_mag_a;
          mag_b_d = start_mag_b;
          // A zero operand forces a positive result so -0 never appears.
          neg_d   = (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]) &&
                    (data_operandA != '0) && (data_operandB != '0);
          dz_d    = (data_operandB == '0);
          dovf_d  = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
          prod_d  = {{WIDTH{1'b0}}, start_mag_b[WIDTH-1:0]};
          rem_d   = '0;
          quo_d   = start_mag_a[WIDTH-1:0];
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_q) begin
          if (!trial[WIDTH+1]) rem_d = trial[WIDTH:0];
          else                 rem_d = rem_shift[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
        end else if (prod_q[0]) begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        end else begin
          prod_d = {1'b0, prod_q[2*WIDTH-1:1]};
        end
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q) begin
          result_d = (dz_q || dovf_q) ? '0 : quo_signed;
          exc_d    = dz_q || dovf_q;
        end else begin
          result_d = prod_signed[WIDTH-1:0];
          exc_d    = (prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}});
        end
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      dovf_q   <= 1'b0;
      cnt_q    <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      dovf_q   <= dovf_d;
      cnt_q    <= cnt_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_seq_multdiv.sv
// Bench for seq_multdiv: directed table, handshake/reset sequences and random ops
// against an arithmetic reference model, on a 32-bit and a 4-bit instance.
module tb_seq_multdiv;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        m32, d32, exc32, rdy32, busy32;
  logic [31:0] a32, b32, res32;
  logic        m4, d4, exc4, rdy4, busy4;
  logic [3:0]  a4, b4, res4;

  int total = 0;
  int bad   = 0;

  seq_multdiv #(.WIDTH(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .ctrl_MULT(m32), .ctrl_DIV(d32),
    .data_operandA(a32), .data_operandB(b32), .data_result(res32),
    .data_exception(exc32), .data_resultRDY(rdy32), .busy(busy32)
  );

  seq_multdiv #(.WIDTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .ctrl_MULT(m4), .ctrl_DIV(d4),
    .data_operandA(a4), .data_operandB(b4), .data_result(res4),
    .data_exception(exc4), .data_resultRDY(rdy4), .busy(busy4)
  );

  typedef struct {
    bit          narrow;
    bit          mul;
    bit          div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    bit          ee;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Signed reference: plain integer multiply/divide on sign-extended operands.
  function automatic void model(input int w, input bit mul, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r, output bit e);
    longint sa, sb, p, lo, hi, mask;
    mask = (longint'(1) << w) - 1;
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (sa >= (longint'(1) << (w - 1))) sa -= (longint'(1) << w);
    if (sb >= (longint'(1) << (w - 1))) sb -= (longint'(1) << w);
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    if (mul) begin
      p = sa * sb;
      e = (p < lo) || (p > hi);
    end else if (sb == 0 || (sa == lo && sb == -1)) begin
      p = 0;
      e = 1'b1;
    end else begin
      p = sa / sb;
      e = 1'b0;
    end
    r = 32'(p & mask);
  endfunction

  task automatic start32(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    m32 = mul; d32 = div; a32 = a; b32 = b;
    @(posedge clock);
    #1;
    m32 = 1'b0; d32 = 1'b0; a32 = $urandom; b32 = $urandom;
  endtask

  task automatic wait32(output int lat, output int bc);
    lat = 0;
    bc  = busy32 ? 1 : 0;
    while (lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
      if (busy32) bc++;
      if (rdy32) break;
    end
  endtask

  task automatic op32(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] r, output logic e, output int lat, output int bc);
    start32(mul, div, a, b);
    wait32(lat, bc);
    r = res32;
    e = exc32;
  endtask

  task automatic op4(input bit mul, input bit div, input logic [3:0] a, input logic [3:0] b,
                     output logic [3:0] r, output logic e, output int lat, output int bc);
    @(negedge clock);
    m4 = mul; d4 = div; a4 = a; b4 = b;
    @(posedge clock);
    #1;
    m4 = 1'b0; d4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0;
    bc  = busy4 ? 1 : 0;
    while (lat < 50) begin
      @(posedge clock);
      #1;
      lat++;
      if (busy4) bc++;
      if (rdy4) break;
    end
    r = res4;
    e = exc4;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return $urandom & 32'h0000_FFFF;
      5: return 32'(-int'($urandom_range(1, 70000)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, er;
    logic        e;
    bit          ee, mul, div;
    logic [3:0]  r4;
    int          lat, bc, npulse, first_at;

    reset_n = 1'b0;
    m32 = 0; d32 = 0; a32 = '0; b32 = '0;
    m4 = 0; d4 = 0; a4 = '0; b4 = '0;

    tbl[0]  = '{0, 1, 0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 0};
    tbl[1]  = '{0, 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1};
    tbl[2]  = '{0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[3]  = '{0, 0, 1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0};
    tbl[4]  = '{0, 0, 1, 32'd100,       32'h0000_0000, 32'h0000_0000, 1};
    tbl[5]  = '{0, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    tbl[6]  = '{1, 1, 0, 32'h7,         32'hF,         32'h9,         0};
    tbl[7]  = '{1, 1, 0, 32'h8,         32'hF,         32'h8,         1};
    tbl[8]  = '{1, 0, 1, 32'h8,         32'h3,         32'hE,         0};
    tbl[9]  = '{0, 1, 1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0};
    tbl[10] = '{0, 0, 1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 0};
    tbl[11] = '{0, 0, 1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 0};

    #2;
    chk("reset_result32", res32, 0);
    chk("reset_flags32", {exc32, rdy32, busy32}, 0);
    chk("reset_all4", {res4, exc4, rdy4, busy4}, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].narrow) begin
        op4(tbl[i].mul, tbl[i].div, tbl[i].a[3:0], tbl[i].b[3:0], r4, e, lat, bc);
        chk($sformatf("tbl%0d_result", i), r4, tbl[i].er[3:0]);
        chk($sformatf("tbl%0d_latency", i), lat, 5);
        chk($sformatf("tbl%0d_busy_cycles", i), bc, 5);
        @(posedge clock); #1;
        chk($sformatf("tbl%0d_rdy_one_cycle", i), rdy4, 0);
      end else begin
        op32(tbl[i].mul, tbl[i].div, tbl[i].a, tbl[i].b, r, e, lat, bc);
        chk($sformatf("tbl%0d_result", i), r, tbl[i].er);
        chk($sformatf("tbl%0d_latency", i), lat, 33);
        chk($sformatf("tbl%0d_busy_cycles", i), bc, 33);
        @(posedge clock); #1;
        chk($sformatf("tbl%0d_rdy_one_cycle", i), rdy32, 0);
      end
      chk($sformatf("tbl%0d_exception", i), e, tbl[i].ee);
    end

    // A divide request arriving mid-multiply must be dropped.
    start32(1, 0, 32'hFFFF_FFFD, 32'd5);
    repeat (4) @(posedge clock);
    @(negedge clock);
    d32 = 1'b1; a32 = 32'd100; b32 = 32'd0;
    @(posedge clock);
    #1;
    d32 = 1'b0;
    npulse = 0; first_at = 0; r = '0; e = 1'b0;
    for (int k = 6; k <= 85; k++) begin
      @(posedge clock);
      #1;
      if (rdy32) begin
        npulse++;
        if (npulse == 1) begin
          first_at = k; r = res32; e = exc32;
        end
      end
    end
    chk("ignored_start_pulses", npulse, 1);
    chk("ignored_start_rdy_edge", first_at, 33);
    chk("ignored_start_result", {e, r}, {1'b0, 32'hFFFF_FFF1});

    // Back-to-back: start requested during the ready cycle.
    op32(1, 0, 32'd1234, 32'hFFFF_FFC8, r, e, lat, bc);
    chk("b2b_first_result", {e, r}, {1'b0, 32'(-69104)});
    m32 = 1'b1; a32 = 32'hFFFF_FFF7; b32 = 32'd11;
    @(posedge clock);
    #1;
    m32 = 1'b0;
    wait32(lat, bc);
    chk("b2b_second_latency", lat, 33);
    chk("b2b_second_result", {exc32, res32}, {1'b0, 32'hFFFF_FF9D});

    // Asynchronous reset in the middle of an operation.
    start32(1, 0, 32'h0001_2345, 32'h0000_0777);
    repeat (10) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_result", res32, 0);
    chk("async_reset_flags", {exc32, rdy32, busy32}, 0);
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b1;
    npulse = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clock);
      #1;
      if (rdy32 || busy32) npulse++;
    end
    chk("aborted_op_activity", npulse, 0);
    op32(1, 0, 32'd6, 32'd7, r, e, lat, bc);
    chk("post_reset_mult", {e, r}, {1'b0, 32'd42});
    chk("post_reset_latency", lat, 33);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      int mode;
      ra = rnd32();
      rb = rnd32();
      mode = $urandom_range(0, 2);
      mul = (mode != 1);
      div = (mode != 0);
      model(32, mul, ra, rb, er, ee);
      op32(mul, div, ra, rb, r, e, lat, bc);
      chk($sformatf("rand32_%0d(%0d,%h,%h)", i, mode, ra, rb), {lat[7:0], e, r}, {8'd33, ee, er});
    end

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      int mode;
      ra = 32'($urandom_range(0, 15));
      rb = 32'($urandom_range(0, 15));
      mode = $urandom_range(0, 2);
      mul = (mode != 1);
      div = (mode != 0);
      model(4, mul, ra, rb, er, ee);
      op4(mul, div, ra[3:0], rb[3:0], r4, e, lat, bc);
      chk($sformatf("rand4_%0d(%0d,%h,%h)", i, mode, ra[3:0], rb[3:0]), {lat[7:0], e, r4},
          {8'd5, ee, er[3:0]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
